// File: rtl/reg_dump_pkg.sv
// Shared constants for the register-file dump engine: FSM encoding, byte
// counts and the per-register header format.
package reg_dump_pkg;

  localparam int unsigned BYTES_PER_REG = 8;
  localparam int unsigned WORD_W        = BYTES_PER_REG * 8;
  localparam int unsigned IDX_W         = 5;
  localparam int unsigned STATE_W       = 3;

  localparam logic [STATE_W-1:0] S_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] S_REQ  = 3'd1;
  localparam logic [STATE_W-1:0] S_HDR  = 3'd2;
  localparam logic [STATE_W-1:0] S_DATA = 3'd3;
  localparam logic [STATE_W-1:0] S_DONE = 3'd4;

  localparam logic [2:0] HDR_PAD = 3'b000;

  // Header byte announcing which register follows.
  function automatic logic [7:0] hdr_byte(input logic [IDX_W-1:0] idx);
    return {HDR_PAD, idx};
  endfunction

endpackage

// File: rtl/reg_dump_byte_serializer.sv
// Loads one 64-bit word (optionally prefixed by a header byte) and shifts it
// out LSB byte first over valid/ready, flagging the final byte.
module byte_serializer
  import reg_dump_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  input  logic              hdr_en,
  input  logic [7:0]        hdr,
  output logic              valid,
  output logic [7:0]        data,
  input  logic              ready,
  output logic              last_c
);

  localparam int unsigned SH_W  = WORD_W + 8;
  localparam int unsigned CNT_W = 4;

  logic [SH_W-1:0]  sh_q;
  logic [CNT_W-1:0] rem_q;

  // Header sits in the low byte so it leaves first; zeros fill in behind.
  always_ff @(posedge clock) begin
    if (reset) begin
      sh_q  <= '0;
      rem_q <= '0;
      valid <= 1'b0;
    end else if (load) begin
      sh_q  <= hdr_en ? {word, hdr} : {8'h00, word};
      rem_q <= hdr_en ? CNT_W'(BYTES_PER_REG + 1) : CNT_W'(BYTES_PER_REG);
      valid <= 1'b1;
    end else if (valid && ready) begin
      sh_q  <= sh_q >> 8;
      rem_q <= rem_q - CNT_W'(1);
      valid <= (rem_q != CNT_W'(1));
    end
  end

  assign data   = sh_q[7:0];
  assign last_c = valid && (rem_q == CNT_W'(1));

endmodule

// File: rtl/reg_dump.sv
// Debug read-out engine: walks every register through one register-file read
// port and streams each value out as bytes over valid/ready.
module reg_dump
  import reg_dump_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned SEND_INDEX = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  rf_addr,
  input  logic [WORD_W-1:0] rf_data,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready
);

  localparam int unsigned LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  logic [STATE_W-1:0] state_q, state_n;
  logic [IDX_W-1:0]   idx_q, idx_n;
  logic [LAT_W-1:0]   lat_q, lat_n;
  logic               load_c;
  logic               ser_last_c;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      lat_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      lat_q   <= lat_n;
      busy    <= (state_n == S_REQ) || (state_n == S_HDR) || (state_n == S_DATA);
      done    <= (state_n == S_DONE);
    end
  end

  // idx only moves on entry to REQ, so the read address stays put otherwise.
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    lat_n   = lat_q;
    load_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_n = S_REQ;
          idx_n   = '0;
          lat_n   = '0;
        end
      end
      S_REQ: begin
        if (lat_q == LAT_W'(RD_LATENCY - 1)) begin
          load_c  = 1'b1;
          state_n = (SEND_INDEX != 0) ? S_HDR : S_DATA;
        end else begin
          lat_n = lat_q + LAT_W'(1);
        end
      end
      S_HDR: begin
        if (tx_valid && tx_ready) state_n = S_DATA;
      end
      S_DATA: begin
        if (ser_last_c && tx_ready) begin
          if (idx_q == IDX_W'(NUM_REGS - 1)) begin
            state_n = S_DONE;
          end else begin
            state_n = S_REQ;
            idx_n   = idx_q + IDX_W'(1);
            lat_n   = '0;
          end
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign rf_addr = idx_q;

  byte_serializer u_ser (
    .clock  (clock),
    .reset  (reset),
    .load   (load_c),
    .word   (rf_data),
    .hdr_en (SEND_INDEX != 0),
    .hdr    (hdr_byte(idx_q)),
    .valid  (tx_valid),
    .data   (tx_data),
    .ready  (tx_ready),
    .last_c (ser_last_c)
  );

endmodule

// File: tb/tb_reg_dump.sv
// Randomized self-checking bench for reg_dump: a byte-stream model derived
// from the register contents, checked every cycle, plus literal pins.
module tb_reg_dump;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_a, start_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [4:0]  rf_addr_a, rf_addr_b;
  logic [63:0] rf_data_a, rf_data_b;
  logic        tx_valid_a, tx_valid_b;
  logic [7:0]  tx_data_a, tx_data_b;
  logic        tx_ready_a;
  logic        tx_ready_b;

  always #5 clock = ~clock;

  reg_dump dut_a (
    .clock(clock), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
    .rf_addr(rf_addr_a), .rf_data(rf_data_a), .tx_valid(tx_valid_a),
    .tx_data(tx_data_a), .tx_ready(tx_ready_a)
  );

  reg_dump #(.NUM_REGS(32), .RD_LATENCY(3), .SEND_INDEX(0)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
    .rf_addr(rf_addr_b), .rf_data(rf_data_b), .tx_valid(tx_valid_b),
    .tx_data(tx_data_b), .tx_ready(tx_ready_b)
  );

  // Register-file model: latency 2 -> one flop, latency 3 -> two flops.
  logic [63:0] regs [0:31];
  logic [63:0] rfb_d1;
  always @(posedge clock) begin
    rf_data_a <= regs[rf_addr_a];
    rfb_d1    <= regs[rf_addr_b];
    rf_data_b <= rfb_d1;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int cyc = 0, rdy_mode = 0;
  int ptr = 0, ptrb = 0;
  int busy_tot = 0, stall_tot = 0, done_tot = 0, busyb_tot = 0;
  bit prev_hold = 0, done_seen = 0;
  logic [7:0] prev_data;
  logic [7:0] cap_q[$];
  logic [7:0] base_q[$];
  int b0, s0, d0, nmis, c, first, donec;
  bit got;
  logic [7:0] ord [0:8];

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // k-th byte of a full dump: optional index header, then value bytes LSB first.
  function automatic logic [7:0] model_byte(input int k, input bit hdr);
    int per, r, o;
    per = hdr ? 9 : 8;
    r = k / per;
    o = k % per;
    if (hdr && o == 0) return 8'(r);
    return regs[r][8*(o - int'(hdr)) +: 8];
  endfunction

  // One clock: check outputs at negedge, then drive tx_ready after posedge.
  task automatic tick();
    @(negedge clock);
    done_seen = 0;
    if (!reset) begin
      if (prev_hold)
        chk(tx_valid_a && tx_data_a == prev_data, "hold_stable", 64'(tx_data_a), 64'(prev_data));
      if (tx_valid_a && tx_ready_a) begin
        if (ptr < 32*9) chk(tx_data_a == model_byte(ptr, 1'b1), "byte_a", 64'(tx_data_a), 64'(model_byte(ptr, 1'b1)));
        else chk(1'b0, "extra_byte_a", 64'(ptr), 64'(32*9));
        cap_q.push_back(tx_data_a);
        ptr++;
      end
      if (tx_valid_b && tx_ready_b) begin
        if (ptrb < 32*8) chk(tx_data_b == model_byte(ptrb, 1'b0), "byte_b", 64'(tx_data_b), 64'(model_byte(ptrb, 1'b0)));
        else chk(1'b0, "extra_byte_b", 64'(ptrb), 64'(32*8));
        ptrb++;
      end
      if (busy_a) busy_tot++;
      if (tx_valid_a && !tx_ready_a) stall_tot++;
      if (done_a) done_tot++;
      if (busy_b) busyb_tot++;
      done_seen = done_a;
      prev_hold = tx_valid_a && !tx_ready_a;
      prev_data = tx_data_a;
    end else begin
      prev_hold = 0;
    end
    @(posedge clock);
    #1;
    cyc++;
    case (rdy_mode)
      0:       tx_ready_a = 1'b1;
      1:       tx_ready_a = (cyc % 3 == 0);
      default: tx_ready_a = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic wait_done_a();
    bit g;
    g = 0;
    for (int k = 0; k < 6000 && !g; k++) begin
      tick();
      g = done_seen;
    end
    chk(g, "done_timeout_a", 64'(g), 64'(1));
  endtask

  // Full dump on dut_a with early-timing checks; caller samples counters.
  task automatic run_dump_a();
    ptr = 0;
    cap_q.delete();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk(busy_a == 1'b1 && rf_addr_a == 5'd0, "cycle1_req", {busy_a, 3'b0, rf_addr_a}, 64'h100);
    chk(tx_valid_a == 1'b0, "cycle1_no_valid", 64'(tx_valid_a), 64'(0));
    tick();
    tick();
    chk(tx_valid_a == 1'b1 && tx_data_a == 8'h00, "cycle3_hdr", {tx_valid_a, tx_data_a}, 64'h100);
    wait_done_a();
    chk(ptr == 32*9, "byte_count_a", 64'(ptr), 64'(32*9));
  endtask

  task automatic fill_basic();
    for (int i = 0; i < 32; i++) regs[i] = 64'h0101_0101_0101_0101 * 64'(i);
    regs[31] = 64'd0;
  endtask

  initial begin
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; tx_ready_a = 1'b1; tx_ready_b = 1'b1;
    fill_basic();
    tick(); tick();
    chk(busy_a == 0 && done_a == 0 && tx_valid_a == 0 && tx_data_a == 0 && rf_addr_a == 0,
        "reset_values_a", {busy_a, done_a, tx_valid_a, tx_data_a, rf_addr_a}, 64'd0);
    chk(busy_b == 0 && done_b == 0 && tx_valid_b == 0 && tx_data_b == 0 && rf_addr_b == 0,
        "reset_values_b", {busy_b, done_b, tx_valid_b, tx_data_b, rf_addr_b}, 64'd0);
    reset = 1'b0;
    tick();

    // Model pins against hand-computed stream positions.
    chk(model_byte(0, 1'b1) == 8'h00 && model_byte(9, 1'b1) == 8'h01 && model_byte(10, 1'b1) == 8'h01,
        "model_pin_head", 64'(model_byte(9, 1'b1)), 64'h01);
    chk(model_byte(279, 1'b1) == 8'h1F && model_byte(280, 1'b1) == 8'h00,
        "model_pin_tail", 64'(model_byte(279, 1'b1)), 64'h1F);

    // Basic dump, tx_ready held high.
    rdy_mode = 0;
    b0 = busy_tot; d0 = done_tot;
    run_dump_a();
    chk(busy_tot - b0 == 352, "busy_cycles_basic", 64'(busy_tot - b0), 64'd352);
    tick(); tick(); tick();
    chk(done_tot - d0 == 1, "done_once_basic", 64'(done_tot - d0), 64'd1);
    chk(cap_q.size() == 288 && cap_q[9] == 8'h01 && cap_q[17] == 8'h01, "dut_reg1_bytes",
        64'(cap_q[9]), 64'h01);
    chk(cap_q[279] == 8'h1F && cap_q[287] == 8'h00, "dut_reg31_bytes", 64'(cap_q[279]), 64'h1F);
    base_q = cap_q;

    // Byte order: header then little-endian value bytes.
    regs[5] = 64'h8877_6655_4433_2211;
    run_dump_a();
    ord = '{8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    for (int i = 0; i < 9; i++)
      chk(cap_q[45+i] == ord[i], "byte_order", 64'(cap_q[45+i]), 64'(ord[i]));
    fill_basic();

    // Backpressure: same stream, busy stretched by exactly the stall count.
    rdy_mode = 1;
    b0 = busy_tot; s0 = stall_tot;
    run_dump_a();
    nmis = 0;
    for (int i = 0; i < base_q.size(); i++) if (cap_q[i] != base_q[i]) nmis++;
    chk(nmis == 0 && cap_q.size() == base_q.size(), "bp_same_stream", 64'(nmis), 64'd0);
    chk(busy_tot - b0 == 352 + (stall_tot - s0), "bp_busy_cycles", 64'(busy_tot - b0), 64'(352 + stall_tot - s0));
    chk(stall_tot - s0 > 0, "bp_stalls_seen", 64'(stall_tot - s0), 64'd1);

    // Random register contents and random backpressure.
    for (int i = 0; i < 32; i++) regs[i] = {$urandom, $urandom};
    rdy_mode = 2;
    b0 = busy_tot; s0 = stall_tot;
    run_dump_a();
    chk(busy_tot - b0 == 352 + (stall_tot - s0), "rand_busy_cycles", 64'(busy_tot - b0), 64'(352 + stall_tot - s0));
    fill_basic();

    // Starts while busy and on the DONE cycle are ignored.
    rdy_mode = 0;
    ptr = 0; cap_q.delete();
    b0 = busy_tot; d0 = done_tot; got = 0;
    for (int k = 0; k < 1000 && !got; k++) begin
      start_a = (k == 0 || k == 10 || k == 200 || done_a);
      got = done_a;
      tick();
    end
    start_a = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    chk(got, "ign_done_seen", 64'(got), 64'd1);
    chk(busy_tot - b0 == 352, "ign_one_dump", 64'(busy_tot - b0), 64'd352);
    chk(done_tot - d0 == 1 && busy_a == 1'b0, "ign_one_done", 64'(done_tot - d0), 64'd1);

    // Reset while byte 4 of register 7 is on the bus.
    ptr = 0; cap_q.delete();
    start_a = 1'b1; tick(); start_a = 1'b0;
    for (int k = 0; k < 2000 && cap_q.size() < 68; k++) tick();
    chk(cap_q.size() == 68 && tx_valid_a == 1'b1, "mid_reached", 64'(cap_q.size()), 64'd68);
    reset = 1'b1;
    tick();
    chk(tx_valid_a == 0 && busy_a == 0 && done_a == 0 && rf_addr_a == 0, "mid_reset_state",
        {tx_valid_a, busy_a, done_a, rf_addr_a}, 64'd0);
    reset = 1'b0;
    tick(); tick();
    chk(tx_valid_a == 0 && busy_a == 0, "post_reset_quiet", {tx_valid_a, busy_a}, 64'd0);
    b0 = busy_tot;
    run_dump_a();
    chk(cap_q[0] == 8'h00 && busy_tot - b0 == 352, "restart_dump", 64'(busy_tot - b0), 64'd352);

    // No-header, latency-3 instance.
    ptrb = 0; first = -1; donec = -1; got = 0;
    b0 = busyb_tot;
    start_b = 1'b1; tick(); start_b = 1'b0;
    c = 1;
    for (int k = 0; k < 3000 && !got; k++) begin
      if (tx_valid_b && first < 0) first = c;
      if (done_b) begin
        got = 1; donec = c;
      end else begin
        tick(); c++;
      end
    end
    chk(got, "b_done_timeout", 64'(got), 64'd1);
    chk(first == 4, "b_first_valid_cycle", 64'(first), 64'd4);
    chk(donec == 353 && busyb_tot - b0 == 352, "b_done_cycle", 64'(donec), 64'd353);
    chk(ptrb == 256, "b_byte_count", 64'(ptrb), 64'd256);
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
